// File: rtl/ssd1306_spi_rx_if.sv
// Pin-side SPI signals and framebuffer/display outputs of the SSD1306 receiver.
// master = bench/host side that drives the SPI pins, slave = the receiver.
interface ssd1306_spi_rx_if;
    logic       sck;
    logic       mosi;
    logic       cs_n;
    logic       dc;
    logic       fb_wr;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       display_on;
    logic       invert;
    logic [7:0] contrast;

    modport master (
        output sck, mosi, cs_n, dc,
        input  fb_wr, fb_addr, fb_data, display_on, invert, contrast
    );

    modport slave (
        input  sck, mosi, cs_n, dc,
        output fb_wr, fb_addr, fb_data, display_on, invert, contrast
    );
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SPI mode-0 slave receiver and SSD1306 command decoder with framebuffer write port.
// Define SSD1306_CONTRAST_EN to implement the 0x81 contrast command.
module ssd1306_spi_rx #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] RESET_CONTRAST = 8'h7F
) (
    input  logic          clk,
    input  logic          rst,
    ssd1306_spi_rx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ARG_MODE, ARG_COL_S, ARG_COL_E, ARG_PG_S, ARG_PG_E, ARG_CONTRAST
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync, dc_sync;
    logic       sck_prev;
    logic       sck_rise;
    logic       cs_idle;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       byte_done;
    logic [7:0] byte_p1;
    logic       dc_p1;

    state_t     state, state_n;
    logic [1:0] addr_mode, addr_mode_n;
    logic [6:0] col, col_n, col_start, col_start_n, col_end, col_end_n;
    logic [2:0] page, page_n, page_start, page_start_n, page_end, page_end_n;
    logic       display_on_q, display_on_n, invert_q, invert_n;
    logic       fb_wr_q, fb_wr_n;
    logic [9:0] fb_addr_q, fb_addr_n;
    logic [7:0] fb_data_q, fb_data_n;

    // Stage 0: pin synchronisers (free-running, they flush during reset)
    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
        dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.dc};
        sck_prev  <= sck_sync[SYNC_STAGES-1];
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign cs_idle  = cs_sync[SYNC_STAGES-1];

    // Stage 1: deserialiser; byte_done pulses on the 8th edge
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_idle) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sck_rise && !cs_idle) begin
            shift   <= {shift[5:0], mosi_sync[SYNC_STAGES-1]};
            byte_p1 <= {shift, mosi_sync[SYNC_STAGES-1]};
            dc_p1   <= dc_sync[SYNC_STAGES-1];
        end
    end

`ifdef SSD1306_CONTRAST_EN
    logic [7:0] contrast_q, contrast_n;
`endif

    // Stage 2: command parser, address pointers and write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_mode    <= 2'd2;
            col          <= '0;
            page         <= '0;
            col_start    <= '0;
            col_end      <= 7'd127;
            page_start   <= '0;
            page_end     <= 3'd7;
            display_on_q <= 1'b0;
            invert_q     <= 1'b0;
            fb_wr_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
`ifdef SSD1306_CONTRAST_EN
            contrast_q   <= RESET_CONTRAST;
`endif
        end else begin
            state        <= state_n;
            addr_mode    <= addr_mode_n;
            col          <= col_n;
            page         <= page_n;
            col_start    <= col_start_n;
            col_end      <= col_end_n;
            page_start   <= page_start_n;
            page_end     <= page_end_n;
            display_on_q <= display_on_n;
            invert_q     <= invert_n;
            fb_wr_q      <= fb_wr_n;
            fb_addr_q    <= fb_addr_n;
            fb_data_q    <= fb_data_n;
`ifdef SSD1306_CONTRAST_EN
            contrast_q   <= contrast_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        addr_mode_n  = addr_mode;
        col_n        = col;
        page_n       = page;
        col_start_n  = col_start;
        col_end_n    = col_end;
        page_start_n = page_start;
        page_end_n   = page_end;
        display_on_n = display_on_q;
        invert_n     = invert_q;
        fb_wr_n      = 1'b0;
        fb_addr_n    = fb_addr_q;
        fb_data_n    = fb_data_q;
`ifdef SSD1306_CONTRAST_EN
        contrast_n   = contrast_q;
`endif
        if (byte_done) begin
            if (dc_p1) begin
                // Data bytes are written regardless of parser state
                fb_wr_n   = 1'b1;
                fb_addr_n = {page, col};
                fb_data_n = byte_p1;
                case (addr_mode)
                    2'd0: begin
                        if (col == col_end) begin
                            col_n  = col_start;
                            page_n = (page == page_end) ? page_start : page + 3'd1;
                        end else begin
                            col_n = col + 7'd1;
                        end
                    end
                    2'd1: begin
                        if (page == page_end) begin
                            page_n = page_start;
                            col_n  = (col == col_end) ? col_start : col + 7'd1;
                        end else begin
                            page_n = page + 3'd1;
                        end
                    end
                    default: col_n = col + 7'd1;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_p1[7:1] == 7'b1010_111)
                            display_on_n = byte_p1[0];
                        else if (byte_p1[7:1] == 7'b1010_011)
                            invert_n = byte_p1[0];
                        else if (byte_p1 == 8'h20)
                            state_n = ARG_MODE;
                        else if (byte_p1 == 8'h21)
                            state_n = ARG_COL_S;
                        else if (byte_p1 == 8'h22)
                            state_n = ARG_PG_S;
`ifdef SSD1306_CONTRAST_EN
                        else if (byte_p1 == 8'h81)
                            state_n = ARG_CONTRAST;
`endif
                        else if (byte_p1[7:4] == 4'h0)
                            col_n[3:0] = byte_p1[3:0];
                        else if (byte_p1[7:3] == 5'b00010)
                            col_n[6:4] = byte_p1[2:0];
                        else if (byte_p1[7:3] == 5'b10110)
                            page_n = byte_p1[2:0];
                    end
                    ARG_MODE: begin
                        addr_mode_n = byte_p1[1:0];
                        state_n     = IDLE;
                    end
                    ARG_COL_S: begin
                        col_start_n = byte_p1[6:0];
                        col_n       = byte_p1[6:0];
                        state_n     = ARG_COL_E;
                    end
                    ARG_COL_E: begin
                        col_end_n = byte_p1[6:0];
                        state_n   = IDLE;
                    end
                    ARG_PG_S: begin
                        page_start_n = byte_p1[2:0];
                        page_n       = byte_p1[2:0];
                        state_n      = ARG_PG_E;
                    end
                    ARG_PG_E: begin
                        page_end_n = byte_p1[2:0];
                        state_n    = IDLE;
                    end
                    ARG_CONTRAST: begin
`ifdef SSD1306_CONTRAST_EN
                        contrast_n = byte_p1;
`endif
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    assign bus.fb_wr      = fb_wr_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.display_on = display_on_q;
    assign bus.invert     = invert_q;
`ifdef SSD1306_CONTRAST_EN
    assign bus.contrast   = contrast_q;
`else
    assign bus.contrast   = RESET_CONTRAST;
`endif
endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Testbench for ssd1306_spi_rx: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model of the command set.
module tb_ssd1306_spi_rx;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssd1306_spi_rx_if bus();

    ssd1306_spi_rx #(.SYNC_STAGES(SYNC), .RESET_CONTRAST(8'h7F)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         lat;
    } wr_t;

    typedef struct {
        logic       dcv;
        logic [7:0] b;
        logic       wr;
        logic [9:0] addr;
        logic [7:0] data;
        logic       on;
        logic       inv;
    } vec_t;

    wr_t  dut_q[$];
    wr_t  mdl_q[$];
    time  t_edge8 = 0;
    logic wr_prev = 1'b0;
    logic [9:0] last_addr = '0;

    // Write monitor: records every strobe with its latency from the 8th sck edge
    always @(negedge clk) begin
        if (bus.fb_wr === 1'b1) begin
            wr_t w;
            w.addr = bus.fb_addr;
            w.data = bus.fb_data;
            w.lat  = int'(($time - t_edge8) / 10);
            dut_q.push_back(w);
            checks++;
            if (wr_prev === 1'b1) begin
                errors++;
                $display("FAIL fb_wr_width: strobe high on consecutive cycles, required single cycle");
            end
        end
        wr_prev <= bus.fb_wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model
    logic [1:0] m_mode;
    logic [6:0] m_col, m_cs, m_ce;
    logic [2:0] m_pg, m_ps, m_pe;
    logic       m_on, m_inv;
    logic [7:0] m_con, m_pend;
    int         m_idx;

    task automatic model_reset();
        m_mode = 2'd2; m_col = '0; m_pg = '0;
        m_cs = '0; m_ce = 7'd127; m_ps = '0; m_pe = 3'd7;
        m_on = 1'b0; m_inv = 1'b0; m_con = 8'h7F; m_pend = 8'h00; m_idx = 0;
        mdl_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dcv);
        wr_t w;
        if (dcv) begin
            w.addr = {m_pg, m_col};
            w.data = b;
            w.lat  = LAT;
            mdl_q.push_back(w);
            if (m_mode == 2'd0) begin
                if (m_col == m_ce) begin
                    m_col = m_cs;
                    m_pg  = (m_pg == m_pe) ? m_ps : 3'(m_pg + 1);
                end else m_col = 7'(m_col + 1);
            end else if (m_mode == 2'd1) begin
                if (m_pg == m_pe) begin
                    m_pg  = m_ps;
                    m_col = (m_col == m_ce) ? m_cs : 7'(m_col + 1);
                end else m_pg = 3'(m_pg + 1);
            end else m_col = 7'(m_col + 1);
        end else if (m_pend == 8'h00) begin
            case (b)
                8'hAE: m_on = 1'b0;
                8'hAF: m_on = 1'b1;
                8'hA6: m_inv = 1'b0;
                8'hA7: m_inv = 1'b1;
                8'h20, 8'h21, 8'h22: begin m_pend = b; m_idx = 0; end
                8'h81: begin
`ifdef SSD1306_CONTRAST_EN
                    m_pend = b;
`endif
                end
                default: begin
                    if (b <= 8'h0F) m_col[3:0] = b[3:0];
                    else if (b >= 8'h10 && b <= 8'h17) m_col[6:4] = b[2:0];
                    else if (b >= 8'hB0 && b <= 8'hB7) m_pg = b[2:0];
                end
            endcase
        end else begin
            case (m_pend)
                8'h20: begin m_mode = (b[1:0] == 2'd3) ? 2'd2 : b[1:0]; m_pend = 8'h00; end
                8'h21: begin
                    if (m_idx == 0) begin m_cs = b[6:0]; m_col = b[6:0]; m_idx = 1; end
                    else begin m_ce = b[6:0]; m_pend = 8'h00; end
                end
                8'h22: begin
                    if (m_idx == 0) begin m_ps = b[2:0]; m_pg = b[2:0]; m_idx = 1; end
                    else begin m_pe = b[2:0]; m_pend = 8'h00; end
                end
                default: begin m_con = b; m_pend = 8'h00; end
            endcase
        end
    endtask

    // SPI mode 0: data set while sck low, sampled on sck rise; 3 clk low, 4 clk high
    task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
        bus.cs_n = 1'b0;
        bus.dc   = dcv;
        for (int i = 0; i < n; i++) begin
            bus.mosi = b[7-i];
            repeat (3) @(negedge clk);
            bus.sck = 1'b1;
            if (i == 7) t_edge8 = $time;
            repeat (4) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dcv);
        send_bits(b, 8, dcv);
        model_byte(b, dcv);
    endtask

    task automatic check_byte();
        wr_t d, m;
        repeat (3) @(negedge clk);
        chk("wr_count", 32'(dut_q.size()), 32'(mdl_q.size()));
        while (dut_q.size() > 0 && mdl_q.size() > 0) begin
            d = dut_q.pop_front();
            m = mdl_q.pop_front();
            last_addr = d.addr;
            chk("wr_addr", 32'(d.addr), 32'(m.addr));
            chk("wr_data", 32'(d.data), 32'(m.data));
            chk("wr_latency", 32'(d.lat), 32'(m.lat));
        end
        dut_q.delete();
        mdl_q.delete();
        chk("display_on", 32'(bus.display_on), 32'(m_on));
        chk("invert", 32'(bus.invert), 32'(m_inv));
        chk("contrast", 32'(bus.contrast), 32'(m_con));
    endtask

    task automatic xfer(input logic [7:0] b, input logic dcv);
        if ($urandom_range(0, 7) == 0) begin
            bus.cs_n = 1'b1;
            repeat (5) @(negedge clk);
        end
        send_byte(b, dcv);
        check_byte();
    endtask

    task automatic rand_step();
        logic [7:0] a;
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: begin xfer(8'h20, 1'b0); xfer(8'($urandom), 1'b0); end
            1: begin
                a = 8'($urandom_range(0, 127));
                xfer(8'h21, 1'b0);
                if ($urandom_range(0, 3) == 0) xfer(8'($urandom), 1'b1);
                xfer(a | {$urandom_range(0, 1) == 1, 7'd0}, 1'b0);
                if ($urandom_range(0, 4) == 0) xfer(8'($urandom), 1'b0);
                else xfer(8'(a + 8'($urandom_range(0, 3))), 1'b0);
            end
            2: begin
                a = 8'($urandom_range(0, 7));
                xfer(8'h22, 1'b0);
                xfer({5'($urandom), a[2:0]}, 1'b0);
                xfer({5'($urandom), 3'(a[2:0] + 3'($urandom_range(0, 1)))}, 1'b0);
            end
            3: xfer(($urandom_range(0, 1) == 1 ? 8'hAE : 8'hA6) | 8'($urandom_range(0, 1)), 1'b0);
            4: xfer(8'($urandom_range(0, 8'h17)), 1'b0);
            5: xfer(8'hB0 | 8'($urandom_range(0, 7)), 1'b0);
            6: begin xfer(8'h81, 1'b0); xfer(8'($urandom), 1'b0); end
            7: xfer(8'($urandom), 1'b0);
            default: repeat ($urandom_range(1, 6)) xfer(8'($urandom), 1'b1);
        endcase
    endtask

    vec_t vecs[25];

    initial begin
        vecs[0]  = '{1'b1, 8'h55, 1'b1, 10'h000, 8'h55, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hAA, 1'b1, 10'h001, 8'hAA, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h20, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h21, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h7E, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h7F, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h22, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h06, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h07, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h11, 1'b1, 10'h37E, 8'h11, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h22, 1'b1, 10'h37F, 8'h22, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h33, 1'b1, 10'h3FE, 8'h33, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h44, 1'b1, 10'h3FF, 8'h44, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h66, 1'b1, 10'h37E, 8'h66, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h20, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h02, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'hB3, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h05, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h12, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 8'h3C, 1'b1, 10'h1A5, 8'h3C, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 8'hAF, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 8'hA7, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 8'hA6, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 8'hAE, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0};

        rst = 1'b1;
        bus.sck = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1; bus.dc = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_fb_wr", 32'(bus.fb_wr), 32'd0);
        chk("rst_fb_addr", 32'(bus.fb_addr), 32'h000);
        chk("rst_fb_data", 32'(bus.fb_data), 32'h00);
        chk("rst_display_on", 32'(bus.display_on), 32'd0);
        chk("rst_invert", 32'(bus.invert), 32'd0);
        chk("rst_contrast", 32'(bus.contrast), 32'h7F);

        // Directed vectors
        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v = vecs[i];
            send_byte(v.b, v.dcv);
            repeat (3) @(negedge clk);
            if (v.wr) begin
                chk("tbl_wr_count", 32'(dut_q.size()), 32'd1);
                if (dut_q.size() > 0) begin
                    chk("tbl_addr", 32'(dut_q[0].addr), 32'(v.addr));
                    chk("tbl_data", 32'(dut_q[0].data), 32'(v.data));
                    chk("tbl_latency", 32'(dut_q[0].lat), 32'(LAT));
                end
            end else begin
                chk("tbl_no_wr", 32'(dut_q.size()), 32'd0);
            end
            chk("tbl_display_on", 32'(bus.display_on), 32'(v.on));
            chk("tbl_invert", 32'(bus.invert), 32'(v.inv));
            dut_q.delete();
            mdl_q.delete();
        end

        // Page mode: column runs from 0x26 up to 127 and wraps to 0 on the same page
        for (int k = 0; k < 91; k++) begin
            send_byte(8'($urandom), 1'b1);
            check_byte();
            if (k == 89) chk("pg_col127", 32'(last_addr), 32'h1FF);
            if (k == 90) chk("pg_col_wrap", 32'(last_addr), 32'h180);
        end

        // Partial byte discarded by cs_n
        send_bits(8'hFF, 5, 1'b1);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'hAF, 1'b0);
        check_byte();
        chk("cs_abort_display_on", 32'(bus.display_on), 32'd1);

        // Contrast command (or its absence)
        send_byte(8'h81, 1'b0);
        send_byte(8'h20, 1'b0);
        check_byte();
`ifdef SSD1306_CONTRAST_EN
        chk("contrast_set", 32'(bus.contrast), 32'h20);
`else
        chk("contrast_fixed", 32'(bus.contrast), 32'h7F);
`endif
        xfer(8'h00, 1'b0);
        repeat (3) xfer(8'($urandom), 1'b1);

        // Randomized traffic
        for (int it = 0; it < 120; it++) rand_step();

        // Reset in the middle of a data byte
        xfer(8'hAF, 1'b0);
        xfer(8'hA7, 1'b0);
        xfer(8'h5A, 1'b1);
        send_bits(8'hC3, 4, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        chk("rst_mid_no_wr", 32'(dut_q.size()), 32'd0);
        chk("rst_mid_fb_wr", 32'(bus.fb_wr), 32'd0);
        chk("rst_mid_fb_addr", 32'(bus.fb_addr), 32'h000);
        chk("rst_mid_fb_data", 32'(bus.fb_data), 32'h00);
        chk("rst_mid_display_on", 32'(bus.display_on), 32'd0);
        chk("rst_mid_invert", 32'(bus.invert), 32'd0);
        chk("rst_mid_contrast", 32'(bus.contrast), 32'h7F);
        dut_q.delete();
        send_byte(8'h55, 1'b1);
        check_byte();
        chk("rst_mid_next_addr", 32'(last_addr), 32'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
